// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions used by the register-bank slave and its master.
package axi4_lite_pkg;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_STRB_W = 4;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic {R_IDLE, R_RESP} rd_state_e;

  // Whole-word compare so upper address bits alias nothing.
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned num_regs);
    return addr < (num_regs * 4);
  endfunction
endpackage

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite register bank: buffered AW/W commit into byte-strobed registers,
// two-state read channel, per-register write pulses to the hardware side.
module axi4_lite_slave_regs
  import axi4_lite_pkg::*;
#(
  parameter int          NUM_REGS    = 16,
  parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [31:0]                S_AXI_AWADDR,
  input  logic                       S_AXI_AWVALID,
  output logic                       S_AXI_AWREADY,
  input  logic [AXI_DATA_W-1:0]      S_AXI_WDATA,
  input  logic [AXI_STRB_W-1:0]      S_AXI_WSTRB,
  input  logic                       S_AXI_WVALID,
  output logic                       S_AXI_WREADY,
  output logic [1:0]                 S_AXI_BRESP,
  output logic                       S_AXI_BVALID,
  input  logic                       S_AXI_BREADY,
  input  logic [31:0]                S_AXI_ARADDR,
  input  logic                       S_AXI_ARVALID,
  output logic                       S_AXI_ARREADY,
  output logic [AXI_DATA_W-1:0]      S_AXI_RDATA,
  output logic [1:0]                 S_AXI_RRESP,
  output logic                       S_AXI_RVALID,
  input  logic                       S_AXI_RREADY,
  output logic [NUM_REGS*32-1:0]     reg_q,
  output logic [NUM_REGS-1:0]        reg_wr_pulse
);
  localparam int IDX_W = $clog2(NUM_REGS);

  logic                  aw_full, aw_hit;
  logic [IDX_W-1:0]      aw_idx;
  logic                  w_full;
  logic [AXI_DATA_W-1:0] w_data;
  logic [AXI_STRB_W-1:0] w_strb;
  logic                  commit, b_hs, ar_hs;
  logic [AXI_DATA_W-1:0] regs [NUM_REGS];
  rd_state_e             rd_state, rd_next;

  assign S_AXI_AWREADY = !aw_full;
  assign S_AXI_WREADY  = !w_full;
  // BVALID gates commit so a held buffer pair commits exactly once.
  assign commit = aw_full & w_full & !S_AXI_BVALID;
  assign b_hs   = S_AXI_BVALID & S_AXI_BREADY;

  // Write address buffer: decode once at capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_full <= 1'b0;
      aw_hit  <= 1'b0;
      aw_idx  <= '0;
    end else if (b_hs) begin
      aw_full <= 1'b0;
    end else if (S_AXI_AWVALID && S_AXI_AWREADY) begin
      aw_full <= 1'b1;
      aw_hit  <= addr_in_range(S_AXI_AWADDR, NUM_REGS);
      aw_idx  <= S_AXI_AWADDR[2 +: IDX_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_full <= 1'b0;
      w_data <= '0;
      w_strb <= '0;
    end else if (b_hs) begin
      w_full <= 1'b0;
    end else if (S_AXI_WVALID && S_AXI_WREADY) begin
      w_full <= 1'b1;
      w_data <= S_AXI_WDATA;
      w_strb <= S_AXI_WSTRB;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= AXI_RESP_OKAY;
      reg_wr_pulse <= '0;
    end else begin
      reg_wr_pulse <= '0;
      if (commit) begin
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= aw_hit ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
        if (aw_hit) reg_wr_pulse[aw_idx] <= 1'b1;
      end else if (b_hs) begin
        S_AXI_BVALID <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    logic            wr_en;
    logic [AXI_DATA_W-1:0] r;

    assign wr_en = commit & aw_hit & (aw_idx == IDX_W'(i));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r <= RESET_VALUE;
      end else if (wr_en) begin
        for (int k = 0; k < AXI_STRB_W; k++)
          if (w_strb[k]) r[8*k +: 8] <= w_data[8*k +: 8];
      end
    end

    assign regs[i]            = r;
    assign reg_q[32*i +: 32]  = r;
  end

  // Read channel: ARREADY only in R_IDLE, so one read per two cycles.
  assign S_AXI_RVALID  = (rd_state == R_RESP);
  assign S_AXI_ARREADY = (rd_state == R_IDLE);
  assign ar_hs         = S_AXI_ARVALID & S_AXI_ARREADY;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_state <= R_IDLE;
    else        rd_state <= rd_next;
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      R_IDLE: if (S_AXI_ARVALID) rd_next = R_RESP;
      R_RESP: if (S_AXI_RREADY)  rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  // Sampled with the write on the same edge, so a colliding read sees the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S_AXI_RDATA <= '0;
      S_AXI_RRESP <= AXI_RESP_OKAY;
    end else if (ar_hs) begin
      if (addr_in_range(S_AXI_ARADDR, NUM_REGS)) begin
        S_AXI_RDATA <= regs[S_AXI_ARADDR[2 +: IDX_W]];
        S_AXI_RRESP <= AXI_RESP_OKAY;
      end else begin
        S_AXI_RDATA <= '0;
        S_AXI_RRESP <= AXI_RESP_SLVERR;
      end
    end
  end
endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Directed bench for the AXI4-Lite register bank: vector table plus
// hand-timed sequences for latency, ordering, backpressure, collision and reset.
module tb_axi4_lite_slave_regs;
  import axi4_lite_pkg::*;

  localparam int          NR = 16;
  localparam logic [31:0] RV = 32'h0000_0000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [31:0]       awaddr = '0, wdata = '0, araddr = '0;
  logic              awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [3:0]        wstrb = '0;
  logic              awready, wready, bvalid, arready, rvalid;
  logic [1:0]        bresp, rresp;
  logic [31:0]       rdata;
  logic [NR*32-1:0]  reg_q;
  logic [NR-1:0]     reg_wr_pulse;

  axi4_lite_slave_regs #(.NUM_REGS(NR), .RESET_VALUE(RV)) dut (
    .clk(clk), .rst_n(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [NR];

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;   // write: new register value; read: RDATA
    logic [1:0]  exp_resp;
    logic [15:0] exp_pulse;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NR; i++)
      check($sformatf("%s reg_q[%0d]", tag, i), reg_q[32*i +: 32], model[i]);
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output logic [15:0] pulse);
    int n = 0;
    logic aw_hs, w_hs;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    while ((awvalid || wvalid) && n < 20) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(negedge clk); n++;
      if (aw_hs) awvalid = 1'b0;
      if (w_hs)  wvalid  = 1'b0;
    end
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    resp = bresp;
    pulse = reg_wr_pulse;
    if (n >= 20) begin
      timeout("write handshake");
      awvalid = 1'b0; wvalid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n = 0;
    logic hs;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    while (arvalid && n < 20) begin
      hs = arready;
      @(negedge clk); n++;
      if (hs) arvalid = 1'b0;
    end
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    d = rdata;
    resp = rresp;
    if (n >= 20) begin
      timeout("read handshake");
      arvalid = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [1:0]  resp;
    logic [15:0] pulse;
    logic [31:0] d;

    // Table: writes first (model updated from exp_data on OKAY), then reads.
    vecs[0]  = '{1'b1, 32'h08, 32'hAAAA_AAAA, 4'hF, 32'hAAAA_AAAA, AXI_RESP_OKAY,   16'h0004};
    vecs[1]  = '{1'b1, 32'h0C, 32'h0000_0009, 4'hF, 32'h0000_0009, AXI_RESP_OKAY,   16'h0008};
    vecs[2]  = '{1'b1, 32'h3C, 32'h1234_5678, 4'h8, 32'h1200_0000, AXI_RESP_OKAY,   16'h8000};
    vecs[3]  = '{1'b1, 32'h00, 32'hFFFF_FFFF, 4'h0, 32'h0000_0000, AXI_RESP_OKAY,   16'h0001};
    vecs[4]  = '{1'b1, 32'h40, 32'h1234_5678, 4'hF, 32'h0000_0000, AXI_RESP_SLVERR, 16'h0000};
    vecs[5]  = '{1'b1, 32'h13, 32'h0000_BEEF, 4'h3, 32'h0000_BEEF, AXI_RESP_OKAY,   16'h0010};
    vecs[6]  = '{1'b0, 32'h08, 32'h0, 4'h0, 32'hAAAA_AAAA, AXI_RESP_OKAY,   16'h0};
    vecs[7]  = '{1'b0, 32'h3C, 32'h0, 4'h0, 32'h1200_0000, AXI_RESP_OKAY,   16'h0};
    vecs[8]  = '{1'b0, 32'h00, 32'h0, 4'h0, 32'h0000_0000, AXI_RESP_OKAY,   16'h0};
    vecs[9]  = '{1'b0, 32'h07, 32'h0, 4'h0, 32'hDEAD_BEEF, AXI_RESP_OKAY,   16'h0};
    vecs[10] = '{1'b0, 32'h40, 32'h0, 4'h0, 32'h0000_0000, AXI_RESP_SLVERR, 16'h0};
    vecs[11] = '{1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 32'h0000_0000, AXI_RESP_SLVERR, 16'h0};
    vecs[12] = '{1'b0, 32'h10, 32'h0, 4'h0, 32'h0000_BEEF, AXI_RESP_OKAY,   16'h0};

    for (int i = 0; i < NR; i++) model[i] = RV;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst bvalid", 32'(bvalid), 32'd0);
    check("rst rvalid", 32'(rvalid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst awready", 32'(awready), 32'd1);
    check("rst wready", 32'(wready), 32'd1);
    check("rst arready", 32'(arready), 32'd1);
    check("rst bresp", 32'(bresp), 32'd0);
    check("rst rresp", 32'(rresp), 32'd0);
    check("rst rdata", rdata, 32'd0);
    check("rst pulse", 32'(reg_wr_pulse), 32'd0);
    check_regs("rst");

    // AW+W same cycle N -> BVALID, update and pulse at N+2
    awaddr = 32'h04; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("lat N+1 bvalid", 32'(bvalid), 32'd0);
    check("lat N+1 pulse", 32'(reg_wr_pulse), 32'd0);
    check("lat N+1 awready", 32'(awready), 32'd0);
    check("lat N+1 wready", 32'(wready), 32'd0);
    @(negedge clk);
    check("lat N+2 bvalid", 32'(bvalid), 32'd1);
    check("lat N+2 bresp", 32'(bresp), 32'(AXI_RESP_OKAY));
    check("lat N+2 reg1", reg_q[63:32], 32'hDEAD_BEEF);
    check("lat N+2 pulse", 32'(reg_wr_pulse), 32'h0002);
    @(negedge clk);
    check("lat N+3 pulse", 32'(reg_wr_pulse), 32'd0);
    check("lat N+3 bvalid", 32'(bvalid), 32'd0);
    check("lat N+3 awready", 32'(awready), 32'd1);
    model[1] = 32'hDEAD_BEEF;

    for (int v = 0; v < 13; v++) begin
      if (vecs[v].wr) begin
        axi_write(vecs[v].addr, vecs[v].data, vecs[v].strb, resp, pulse);
        check($sformatf("vec%0d bresp", v), 32'(resp), 32'(vecs[v].exp_resp));
        check($sformatf("vec%0d pulse", v), 32'(pulse), 32'(vecs[v].exp_pulse));
        if (vecs[v].exp_resp == AXI_RESP_OKAY) model[vecs[v].addr[5:2]] = vecs[v].exp_data;
        check_regs($sformatf("vec%0d", v));
      end else begin
        axi_read(vecs[v].addr, d, resp);
        check($sformatf("vec%0d rdata", v), d, vecs[v].exp_data);
        check($sformatf("vec%0d rresp", v), 32'(resp), 32'(vecs[v].exp_resp));
      end
    end

    // W two cycles ahead of AW: W buffer holds until the B handshake
    @(negedge clk);
    wdata = 32'h1122_3344; wstrb = 4'b0101; wvalid = 1'b1; bready = 1'b1;
    check("wfirst wready", 32'(wready), 32'd1);
    @(negedge clk);
    wvalid = 1'b0;
    @(negedge clk);
    check("wfirst wready held", 32'(wready), 32'd0);
    check("wfirst awready", 32'(awready), 32'd1);
    check("wfirst bvalid", 32'(bvalid), 32'd0);
    @(negedge clk);
    awaddr = 32'h08; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    check("wfirst N+1 bvalid", 32'(bvalid), 32'd0);
    check("wfirst N+1 wready", 32'(wready), 32'd0);
    @(negedge clk);
    check("wfirst bvalid", 32'(bvalid), 32'd1);
    check("wfirst bresp", 32'(bresp), 32'(AXI_RESP_OKAY));
    check("wfirst pulse", 32'(reg_wr_pulse), 32'h0004);
    check("wfirst wready at B", 32'(wready), 32'd0);
    check("wfirst reg2", reg_q[95:64], 32'hAA22_AA44);
    @(negedge clk);
    check("wfirst after B wready", 32'(wready), 32'd1);
    check("wfirst after B awready", 32'(awready), 32'd1);
    model[2] = 32'hAA22_AA44;

    // Read held under RREADY low for 3 cycles
    rready = 1'b0; araddr = 32'h04; arvalid = 1'b1;
    check("rhold arready", 32'(arready), 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("rhold%0d rvalid", c), 32'(rvalid), 32'd1);
      check($sformatf("rhold%0d rdata", c), rdata, 32'hDEAD_BEEF);
      check($sformatf("rhold%0d rresp", c), 32'(rresp), 32'(AXI_RESP_OKAY));
      check($sformatf("rhold%0d arready", c), 32'(arready), 32'd0);
      @(negedge clk);
    end
    check("rhold still rvalid", 32'(rvalid), 32'd1);
    rready = 1'b1;
    @(negedge clk);
    check("rhold done rvalid", 32'(rvalid), 32'd0);
    check("rhold done arready", 32'(arready), 32'd1);

    // Commit to reg3 and AR of reg3 on the same edge
    awaddr = 32'h0C; wdata = 32'h5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 32'h0C; arvalid = 1'b1; rready = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    check("coll rvalid", 32'(rvalid), 32'd1);
    check("coll rdata old", rdata, 32'h9);
    check("coll bvalid", 32'(bvalid), 32'd1);
    check("coll reg3", reg_q[127:96], 32'h5);
    @(negedge clk);
    model[3] = 32'h5;
    axi_read(32'h0C, d, resp);
    check("coll reread", d, 32'h5);

    // Reset while BVALID is pending
    @(negedge clk);
    bready = 1'b0;
    awaddr = 32'h14; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    check("mrst pre bvalid", 32'(bvalid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mrst bvalid", 32'(bvalid), 32'd0);
    check("mrst awready", 32'(awready), 32'd1);
    check("mrst wready", 32'(wready), 32'd1);
    check("mrst pulse", 32'(reg_wr_pulse), 32'd0);
    for (int i = 0; i < NR; i++) model[i] = RV;
    check_regs("mrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst idle bvalid", 32'(bvalid), 32'd0);
    axi_write(32'h14, 32'h77, 4'hF, resp, pulse);
    check("mrst write bresp", 32'(resp), 32'(AXI_RESP_OKAY));
    check("mrst write pulse", 32'(pulse), 32'h0020);
    model[5] = 32'h77;
    check_regs("mrst post");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi4_lite_slave_regs.md
Name: axi4_lite_slave_regs

Overview:
AXI4-Lite slave register bank that sits directly downstream of the AXI4-Lite master and terminates its five channels. It holds NUM_REGS 32-bit software-visible registers with byte-strobe writes and SLVERR for unmapped addresses. Register contents and per-register write pulses are exported to the surrounding hardware.

Parameters:
NUM_REGS, 16, number of 32-bit registers (power of two, 2..256); mapped at byte offsets 0 .. NUM_REGS*4-1
RESET_VALUE, 32'h0000_0000, reset value of every register

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active low
S_AXI_AWADDR  in  32  write address
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte lane strobes
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  32  read address
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
reg_q  out  NUM_REGS*32  flattened register contents; register i at bits [32*i+31:32*i]
reg_wr_pulse  out  NUM_REGS  one-cycle pulse per register on a committed in-range write

Behaviour:
- Reset (rst_n low, asynchronous): aw_full=0, w_full=0, BVALID=0, RVALID=0, BRESP=0, RRESP=0, RDATA=0, reg_wr_pulse=0, every register = RESET_VALUE. A transaction in flight is discarded; no response is issued for it.
- Decode: addresses below NUM_REGS*4 are in range; index = addr[2 +: log2(NUM_REGS)]. addr[1:0] is ignored. All other addresses are out of range.
- Write address and write data are accepted independently, in either order or in the same cycle:
  - AWREADY = !aw_full. An AW handshake latches AWADDR and sets aw_full.
  - WREADY = !w_full. A W handshake latches WDATA/WSTRB and sets w_full.
- Commit: on the edge ending the first cycle with aw_full & w_full & !BVALID:
  - in range: update byte lane k of reg[index] only if WSTRB[k]; pulse reg_wr_pulse[index] for the following cycle; BRESP=2'b00 (OKAY).
  - out of range: no register changes, no pulse; BRESP=2'b10 (SLVERR).
  - BVALID rises on that edge.
- BVALID, BRESP: held until BREADY. The B handshake edge clears BVALID, aw_full and w_full, so AWREADY/WREADY return high in the next cycle.
- Write latency: AW and W handshaked in cycle N -> register updated and BVALID high in cycle N+2.
- Read path (two states, R_IDLE and R_RESP):
  - ARREADY = !RVALID.
  - An AR handshake in cycle N registers RDATA = reg[index] (in range, RRESP=OKAY) or RDATA=0 with RRESP=SLVERR; RVALID is high in cycle N+1.
  - RVALID, RDATA and RRESP are held until RREADY. The handshake edge clears RVALID; back-to-back reads sustain one read per 2 cycles.
- Simultaneous write commit and AR to the same register on one edge: the read returns the pre-write value.
- The read and write paths are fully independent; neither stalls the other.
- WSTRB=4'b0000 in range: OKAY response and the pulse still fire; data is unchanged.

Decomposition:
- Package axi4_lite_pkg:
  - resp constants AXI_RESP_OKAY=2'b00, AXI_RESP_SLVERR=2'b10
  - read-state enum
  - AXI_DATA_W=32, AXI_STRB_W=4
- The master shares this package.
- No sub-module; one module with a write-buffer block, a read FSM and the register array.

Test Plan:
- Reset, then AW(0x04) and W(0xDEADBEEF, strb 4'hF) in the same cycle N -> BVALID high at N+2 with BRESP=00, reg_q[63:32]=0xDEADBEEF, reg_wr_pulse=16'h0002 for one cycle.
- W(0x11223344, strb 4'b0101) two cycles before AW(0x08) over existing 0xAAAAAAAA -> reg2=0xAA22AA44; AWREADY low between the two handshakes is not required, but WREADY low until the B handshake.
- AR(0x04) with RREADY held low for 3 cycles -> RVALID and RDATA=0xDEADBEEF stable all 3 cycles, ARREADY=0 until the RREADY handshake.
- AW(0x40) with NUM_REGS=16, W(0x12345678) -> BRESP=10, no reg_q change, no pulse; AR(0x40) -> RDATA=0, RRESP=10.
- Same-edge write commit to reg3 (0x5) and AR(0x0C) with old value 0x9 -> RDATA=0x9; a following read -> 0x5.
- rst_n low mid-write, with BVALID=1 pending -> BVALID=0 immediately, all reg_q=RESET_VALUE, next AW/W accepted normally.
